flatten_writer: RTL and testbench
=================================

Name: flatten_writer

Overview:
- Producer side of the fully-connected interface.
- Accepts the pooled feature-map stream one element per cycle over a valid/ready handshake and assembles it into a FLATTENED_LENGTH-element parallel array.
- Drives the array as flattened_outfmap and holds fullyconnect_start high until the fully-connected stage acknowledges with fc_done.
- Uses ping-pong banks, so the next image fills while the current one is consumed.

Parameters:
FLATTENED_LENGTH, 432, elements per frame (flattened feature map length)
DATA_WIDTH, 8, signed element width
CNT_WIDTH, $clog2(FLATTENED_LENGTH), write index width

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream element valid
in_ready  output  1  block can accept an element this cycle
in_data  input  DATA_WIDTH signed  pooled element, in flatten order
in_last  input  1  marks final element of a frame
flattened_outfmap  output  DATA_WIDTH signed x FLATTENED_LENGTH  presented frame
fullyconnect_start  output  1  frame valid; high for the whole presentation
fc_done  input  1  single-cycle pulse from consumer: frame consumed
length_error  output  1  sticky; in_last misaligned with FLATTENED_LENGTH
frame_count  output  16  frames released, wraps at 2^16

Behaviour:
- Reset (async, reset_n=0):
  - All bank contents 0, full[1:0]=0, wr_bank=0, wr_idx=0, rd_bank=0, out state IDLE.
  - Outputs: fullyconnect_start=0, flattened_outfmap all 0, length_error=0, frame_count=0, in_ready=1 after release.
  - A partial frame in progress at reset is discarded.
- Write side:
  - in_ready = !full[wr_bank], combinational from registers only, never from in_valid.
  - An element is accepted when in_valid&&in_ready: bank[wr_bank][wr_idx]<=in_data, wr_idx++.
  - Frame close on accepting wr_idx==FLATTENED_LENGTH-1: full[wr_bank]<=1, wr_bank toggles, wr_idx<=0.
  - Early in_last (wr_idx<FLATTENED_LENGTH-1): length_error<=1, frame closes as above; unwritten entries remain 0.
  - Missing in_last at wr_idx==FLATTENED_LENGTH-1: length_error<=1, frame closes anyway.
  - length_error clears only on reset.
  - Both banks full: in_ready=0; upstream must hold in_data stable until accepted.
- Read-side FSM, states IDLE and PRESENT:
  - IDLE -> PRESENT when full[rd_bank]. fullyconnect_start is registered, so it goes high on that same edge.
  - Latency: final element accepted at edge N; fullyconnect_start high after edge N+1, provided the read side was IDLE and the bank is rd_bank.
  - PRESENT: fullyconnect_start=1 and flattened_outfmap=bank[rd_bank], both stable for the entire state.
  - PRESENT -> IDLE on fc_done at an edge. On that edge:
    - start<=0
    - full[rd_bank]<=0
    - bank[rd_bank] cleared to 0
    - rd_bank toggles
    - frame_count++
  - At least one IDLE cycle separates consecutive frames, so start always shows a falling edge between frames.
  - In IDLE, flattened_outfmap is driven all 0.
  - fc_done in IDLE is ignored, with no state change.
- Simultaneous events:
  - Closing a frame in bank X on the same edge fc_done releases bank Y: both take effect; the new frame presents after the mandatory IDLE cycle.
  - Release of a bank and acceptance into that same bank cannot coincide: the released bank is full, so in_ready is low for it that cycle.
  - A bank freed on edge E can accept an element in the cycle after E.
- Arithmetic: no arithmetic on data. Elements are stored verbatim as signed DATA_WIDTH. The index compare uses CNT_WIDTH unsigned.

Decomposition:
- Shared package cnn_pkg holds:
  - DATA_WIDTH and FLATTENED_LENGTH defaults
  - out-state enum {IDLE, PRESENT}
  - typedef flat_array_t (signed DATA_WIDTH x FLATTENED_LENGTH)
- One sub-module, flatten_bank: single storage bank with write enable, write index, synchronous clear, and a parallel read output. It is instantiated twice.
- Top level holds the pointers, full flags, FSM and error logic.

Test Plan:
- Stream 432 elements with values i mod 128, in_last on the 432nd; fc_done 5 cycles after start rises -> start high one cycle after the final accept; flattened_outfmap[k]=k mod 128; start low after the fc_done edge; frame_count=1.
- Stream three back-to-back frames (values 1, 2, 3) with fc_done withheld -> in_ready drops after frame 2 closes; frame 3's first element stalls until fc_done, then the outputs present all 2s after one IDLE cycle.
- Early in_last on element 100 (index 99) -> length_error=1; presented entries 100..431 are 0; next frame is normal and length_error stays 1.
- Assert reset_n low after element 200 of a frame -> all outputs 0 immediately; after release, a fresh 432-element frame presents correctly.
- Pulse fc_done while IDLE -> no change to start, frame_count or rd_bank.
- in_valid toggling randomly at 50% with data -k -> all 432 values land in order; no element is lost or duplicated.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and types for the pooled-stream to fully-connected handoff.
package cnn_pkg;

    localparam int DATA_WIDTH       = 8;
    localparam int FLATTENED_LENGTH = 432;
    localparam int CNT_WIDTH        = $clog2(FLATTENED_LENGTH);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } out_state_e;

    typedef logic signed [DATA_WIDTH-1:0] elem_t;
    typedef elem_t flat_array_t [FLATTENED_LENGTH];

endpackage

// File: rtl/flatten_writer_if.sv
// Element stream in, flattened frame plus start/done handshake out.
interface flatten_writer_if;
    import cnn_pkg::*;

    logic        in_valid;
    logic        in_ready;
    elem_t       in_data;
    logic        in_last;
    flat_array_t flattened_outfmap;
    logic        fullyconnect_start;
    logic        fc_done;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  fc_done,
        output in_ready,
        output flattened_outfmap,
        output fullyconnect_start
    );

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output fc_done,
        input  in_ready,
        input  flattened_outfmap,
        input  fullyconnect_start
    );

endinterface

// File: rtl/flatten_bank.sv
// One frame of element storage: indexed write, whole-bank synchronous clear,
// full-width parallel read.
module flatten_bank
    import cnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_we,
    input  logic [CNT_WIDTH-1:0] i_idx,
    input  elem_t                i_data,
    input  logic                 i_clr,
    output flat_array_t          o_data
);

    flat_array_t r_mem;

    // Clear wins over write; the top never asserts both for the same bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < FLATTENED_LENGTH; k++) r_mem[k] <= '0;
        end else if (i_clr) begin
            for (int k = 0; k < FLATTENED_LENGTH; k++) r_mem[k] <= '0;
        end else if (i_we) begin
            r_mem[i_idx] <= i_data;
        end
    end

    assign o_data = r_mem;

endmodule

// File: rtl/flatten_writer.sv
// Ping-pong frame assembler feeding the fully-connected stage.
//   state   | meaning
//   IDLE    | nothing presented; outfmap driven 0, waiting for full[rd_bank]
//   PRESENT | bank[rd_bank] presented with start high until fc_done
module flatten_writer
    import cnn_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    flatten_writer_if.slave  bus,
    output logic             length_error,
    output logic [15:0]      frame_count
);

    logic [1:0]           r_full;
    logic                 r_wr_bank;
    logic                 r_rd_bank;
    logic [CNT_WIDTH-1:0] r_wr_idx;
    out_state_e           r_state;
    logic                 r_start;
    logic                 r_length_error;
    logic [15:0]          r_frame_count;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_last_slot;
    logic                 w_close;
    logic                 w_release;
    flat_array_t          w_bank0;
    flat_array_t          w_bank1;
    flat_array_t          w_out;

    assign w_ready     = !r_full[r_wr_bank];
    assign w_accept    = bus.in_valid && w_ready;
    assign w_last_slot = (r_wr_idx == CNT_WIDTH'(FLATTENED_LENGTH - 1));
    assign w_close     = w_accept && (bus.in_last || w_last_slot);
    assign w_release   = (r_state == PRESENT) && bus.fc_done;

    flatten_bank u_bank0 (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_accept && !r_wr_bank),
        .i_idx   (r_wr_idx),
        .i_data  (bus.in_data),
        .i_clr   (w_release && !r_rd_bank),
        .o_data  (w_bank0)
    );

    flatten_bank u_bank1 (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_accept && r_wr_bank),
        .i_idx   (r_wr_idx),
        .i_data  (bus.in_data),
        .i_clr   (w_release && r_rd_bank),
        .o_data  (w_bank1)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_idx       <= '0;
            r_wr_bank      <= 1'b0;
            r_length_error <= 1'b0;
        end else begin
            if (w_close) begin
                r_wr_idx  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else if (w_accept) begin
                r_wr_idx <= r_wr_idx + CNT_WIDTH'(1);
            end
            // Covers both an early in_last and a missing one at the final slot.
            if (w_accept && (bus.in_last != w_last_slot)) r_length_error <= 1'b1;
        end
    end

    // A bank can never be closed and released on the same edge: a released
    // bank is full, so it cannot be the one accepting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_close && (r_wr_bank == 1'(b)))
                    r_full[b] <= 1'b1;
                else if (w_release && (r_rd_bank == 1'(b)))
                    r_full[b] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_start       <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        r_state <= PRESENT;
                        r_start <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (bus.fc_done) begin
                        r_state       <= IDLE;
                        r_start       <= 1'b0;
                        r_rd_bank     <= ~r_rd_bank;
                        r_frame_count <= r_frame_count + 16'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_start <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < FLATTENED_LENGTH; k++) begin
            w_out[k] = (r_state == PRESENT) ? (r_rd_bank ? w_bank1[k] : w_bank0[k]) : '0;
        end
    end

    assign bus.in_ready           = w_ready;
    assign bus.fullyconnect_start = r_start;
    assign bus.flattened_outfmap  = w_out;
    assign length_error           = r_length_error;
    assign frame_count            = r_frame_count;

endmodule

// File: tb/tb_flatten_writer.sv
// Randomized stream bench for flatten_writer with a frame-level reference model.
module tb_flatten_writer;
    import cnn_pkg::*;

    localparam int L = FLATTENED_LENGTH;
    typedef bit signed [DATA_WIDTH-1:0] mframe_t [FLATTENED_LENGTH];

    logic        clk = 1'b0;
    logic        reset_n;
    logic        length_error;
    logic [15:0] frame_count;

    flatten_writer_if bus();

    flatten_writer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .length_error (length_error),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Frame-level model: closed frames wait in a queue (at most two banks),
    // the head is presented one cycle after it becomes eligible.
    mframe_t mq [$];
    mframe_t mcur;
    int      midx;
    bit      mpres;
    int      mcount;
    bit      merr;

    always @(posedge clk or negedge reset_n) begin : model
        int pre_n;
        bit acc;
        bit fin;
        if (!reset_n) begin
            mq.delete();
            for (int k = 0; k < L; k++) mcur[k] = '0;
            midx   = 0;
            mpres  = 1'b0;
            mcount = 0;
            merr   = 1'b0;
        end else begin
            pre_n = mq.size();
            acc   = (bus.in_valid === 1'b1) && (pre_n < 2);
            if (mpres && bus.fc_done === 1'b1) begin
                mpres = 1'b0;
                void'(mq.pop_front());
                mcount = (mcount + 1) % 65536;
            end else if (!mpres && pre_n > 0) begin
                mpres = 1'b1;
            end
            if (acc) begin
                mcur[midx] = bus.in_data;
                fin = (bus.in_last === 1'b1) || (midx == L - 1);
                if ((bus.in_last === 1'b1) != (midx == L - 1)) merr = 1'b1;
                if (fin) begin
                    mq.push_back(mcur);
                    for (int k = 0; k < L; k++) mcur[k] = '0;
                    midx = 0;
                end else begin
                    midx++;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        int   nbad;
        int   first;
        elem_t e;
        if (reset_n === 1'b1) begin
            chk("in_ready", int'(bus.in_ready), int'(mq.size() < 2));
            chk("start", int'(bus.fullyconnect_start), int'(mpres));
            chk("frame_count", int'(frame_count), mcount);
            chk("length_error", int'(length_error), int'(merr));
            nbad  = 0;
            first = -1;
            for (int k = 0; k < L; k++) begin
                e = mpres ? elem_t'(mq[0][k]) : '0;
                if (bus.flattened_outfmap[k] !== e) begin
                    nbad++;
                    if (first < 0) first = k;
                end
            end
            chk($sformatf("outfmap_bad_elems(first=%0d)", first), nbad, 0);
        end
    end

    bit auto_done       = 1'b1;
    int fc_delay        = 5;
    bit idle_pulse_req  = 1'b0;

    initial begin : consumer
        int cnt;
        cnt = 0;
        bus.fc_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.fc_done = 1'b0;
            if (reset_n !== 1'b1) begin
                cnt = 0;
            end else if (idle_pulse_req) begin
                bus.fc_done    = 1'b1;
                idle_pulse_req = 1'b0;
            end else if (bus.fullyconnect_start === 1'b1) begin
                if (auto_done) begin
                    cnt++;
                    if (cnt >= fc_delay) begin
                        bus.fc_done = 1'b1;
                        cnt = 0;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    function automatic elem_t elem_val(input int kind, input int base, input int i);
        case (kind)
            0:       return elem_t'(i % 128);
            1:       return elem_t'(base);
            default: return elem_t'(-i);
        endcase
    endfunction

    // Called and returns at a falling edge; holds data stable while stalled.
    task automatic send(input int n, input int last_pos, input int kind, input int base, input int pct);
        int g;
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) >= pct) begin
                bus.in_valid = 1'b0;
                bus.in_data  = elem_t'($urandom);
                bus.in_last  = 1'b0;
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = elem_val(kind, base, i);
            bus.in_last  = (i == last_pos);
            g = 0;
            while (bus.in_ready !== 1'b1 && g < 3000) begin
                @(negedge clk);
                g++;
            end
            if (g >= 3000) begin
                chk("send_stall_timeout", g, 0);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_level(input bit lvl, input int budget, input string nm);
        int g;
        g = 0;
        while (bus.fullyconnect_start !== lvl && g < budget) begin
            @(negedge clk);
            g++;
        end
        chk(nm, int'(bus.fullyconnect_start), int'(lvl));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int saved;
        int g;
        int nz;
        reset_n      = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_start", int'(bus.fullyconnect_start), 0);
        chk("rst_frame_count", int'(frame_count), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 1);

        // Single frame, i mod 128, full-rate stream.
        send(L, L - 1, 0, 0, 100);
        chk("t1_start_pre", int'(bus.fullyconnect_start), 0);
        @(negedge clk);
        chk("t1_start_latency", int'(bus.fullyconnect_start), 1);
        chk("t1_out0", int'(bus.flattened_outfmap[0]), 0);
        chk("t1_out127", int'(bus.flattened_outfmap[127]), 127);
        chk("t1_out128", int'(bus.flattened_outfmap[128]), 0);
        chk("t1_out431", int'(bus.flattened_outfmap[431]), 47);
        wait_level(1'b0, 50, "t1_start_fall");
        chk("t1_frame_count", int'(frame_count), 1);

        // fc_done in IDLE must be ignored.
        saved = int'(frame_count);
        idle_pulse_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_fc_count", int'(frame_count), saved);
        chk("idle_fc_start", int'(bus.fullyconnect_start), 0);

        // Three frames with the consumer withheld: backpressure on frame 3.
        auto_done = 1'b0;
        send(L, L - 1, 1, 1, 100);
        send(L, L - 1, 1, 2, 100);
        chk("t2_ready_low", int'(bus.in_ready), 0);
        fork
            send(L, L - 1, 1, 3, 100);
            begin
                repeat (20) @(negedge clk);
                chk("t2_stalled", int'(bus.in_ready), 0);
                auto_done = 1'b1;
                wait_level(1'b0, 50, "t2_release");
                @(negedge clk);
                chk("t2_present2", int'(bus.fullyconnect_start), 1);
                chk("t2_val0", int'(bus.flattened_outfmap[0]), 2);
                chk("t2_val431", int'(bus.flattened_outfmap[431]), 2);
            end
        join
        wait_level(1'b1, 100, "t2_frame3_start");
        chk("t2_val3", int'(bus.flattened_outfmap[200]), 3);
        wait_level(1'b0, 100, "t2_frame3_done");
        chk("t2_frame_count", int'(frame_count), 4);

        // Early in_last at index 99.
        send(100, 99, 1, 7, 100);
        wait_level(1'b1, 50, "t3_start");
        chk("t3_length_error", int'(length_error), 1);
        chk("t3_out99", int'(bus.flattened_outfmap[99]), 7);
        chk("t3_out100", int'(bus.flattened_outfmap[100]), 0);
        chk("t3_out431", int'(bus.flattened_outfmap[431]), 0);
        wait_level(1'b0, 50, "t3_done");
        send(L, L - 1, 0, 0, 100);
        wait_level(1'b1, 50, "t3_next_start");
        chk("t3_next_out431", int'(bus.flattened_outfmap[431]), 47);
        chk("t3_err_sticky", int'(length_error), 1);
        wait_level(1'b0, 50, "t3_next_done");

        // Reset while presenting and while a partial frame is in flight.
        auto_done = 1'b0;
        send(L, L - 1, 1, 11, 100);
        wait_level(1'b1, 50, "t4_pre_start");
        send(200, -1, 1, 5, 100);
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("t4_rst_start", int'(bus.fullyconnect_start), 0);
        chk("t4_rst_err", int'(length_error), 0);
        chk("t4_rst_count", int'(frame_count), 0);
        chk("t4_rst_ready", int'(bus.in_ready), 1);
        nz = 0;
        for (int k = 0; k < L; k++) if (bus.flattened_outfmap[k] !== '0) nz++;
        chk("t4_rst_outfmap_nonzero", nz, 0);
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        auto_done = 1'b1;
        @(negedge clk);
        send(L, L - 1, 0, 0, 70);
        wait_level(1'b1, 50, "t4_fresh_start");
        chk("t4_out5", int'(bus.flattened_outfmap[5]), 5);
        chk("t4_out300", int'(bus.flattened_outfmap[300]), 44);
        wait_level(1'b0, 50, "t4_fresh_done");
        chk("t4_err_clean", int'(length_error), 0);

        // Missing in_last at the final slot.
        send(L, -1, 1, 9, 100);
        wait_level(1'b1, 50, "t5_start");
        chk("t5_length_error", int'(length_error), 1);
        chk("t5_out431", int'(bus.flattened_outfmap[431]), 9);
        wait_level(1'b0, 50, "t5_done");

        // Random 50% valid, data -k, random consumer latency.
        for (int f = 0; f < 3; f++) begin
            fc_delay = int'($urandom_range(20, 1));
            send(L, L - 1, 2, 0, 50);
        end
        g = 0;
        while ((bus.fullyconnect_start !== 1'b0 || mq.size() != 0) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk("t6_drained", g < 3000 ? 1 : 0, 1);
        chk("t6_frame_count", int'(frame_count), 5);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
